// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache refill/writeback port: serialised word store with fixed latency.
// Optional CACHE_MEM_RESP_STALL_EN adds LFSR-driven random stalls before the response is presented.
module cache_mem_responder #(
   parameter int p_num_words = 256,
   parameter int p_latency   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [76:0] memreq_msg,
   input  logic        memreq_val,
   output logic        memreq_rdy,
   output logic [46:0] memresp_msg,
   output logic        memresp_val,
   input  logic        memresp_rdy
);

   localparam int         AW  = $clog2(p_num_words);
   localparam logic [3:0] LAT = 4'(p_latency);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   logic [2:0]    req_type;
   logic [7:0]    req_opaque;
   logic [31:0]   req_addr;
   logic [1:0]    req_len;
   logic [31:0]   req_data;
   logic [AW-1:0] req_idx;
   logic          req_wr;
   logic          accept;
   logic          resp_go;
   logic          unused_addr_bits;

   assign req_type   = memreq_msg[76:74];
   assign req_opaque = memreq_msg[73:66];
   assign req_addr   = memreq_msg[65:34];
   assign req_len    = memreq_msg[33:32];
   assign req_data   = memreq_msg[31:0];
   assign req_idx    = req_addr[AW+1:2];
   assign req_wr     = (req_type == 3'd1) || (req_type == 3'd2);

   // Byte offset and bits above the store size are ignored, so addresses wrap.
   assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [2:0]  type_q;
   logic [7:0]  opaque_q;
   logic [1:0]  len_q;
   logic        is_read_q;
   logic        val_q;
   logic        rdy_q;
   logic [31:0] rd_word_q;
   logic [31:0] store_mem [p_num_words];

   assign accept = memreq_val && rdy_q && !reset;

   // Backing store: not cleared by reset; read word is the pre-write value.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (req_wr) begin
            store_mem[req_idx] <= req_data;
         end
         rd_word_q <= store_mem[req_idx];
      end
   end

`ifdef CACHE_MEM_RESP_STALL_EN
   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign resp_go = !lfsr_q[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= 8'hA5;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   assign resp_go = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         type_q    <= 3'd0;
         opaque_q  <= 8'd0;
         len_q     <= 2'd0;
         is_read_q <= 1'b0;
         val_q     <= 1'b0;
         rdy_q     <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  type_q    <= req_type;
                  opaque_q  <= req_opaque;
                  len_q     <= req_len;
                  is_read_q <= (req_type == 3'd0);
                  cnt_q     <= LAT;
                  rdy_q     <= 1'b0;
                  if (p_latency > 0) begin
                     state_q <= WAIT;
                  end else begin
                     state_q <= RESP;
                     val_q   <= resp_go;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= RESP;
                  val_q   <= resp_go;
               end
            end
            RESP: begin
               if (!val_q) begin
                  val_q <= resp_go;
               end else if (memresp_rdy) begin
                  val_q   <= 1'b0;
                  rdy_q   <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               val_q   <= 1'b0;
               rdy_q   <= 1'b1;
            end
         endcase
      end
   end

   // Data field is zero for any non-READ type; is_read_q is cleared by reset so the message reads 0.
   assign memresp_msg = {type_q, opaque_q, 2'b00, len_q, is_read_q ? rd_word_q : 32'h0};
   assign memresp_val = val_q;
   assign memreq_rdy  = rdy_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: latency, ordering, stall hold, wrap and reset-in-flight.
module tb_cache_mem_responder;

   localparam int LAT = 2;

   logic        clk;
   logic        reset;
   logic [76:0] memreq_msg;
   logic        memreq_val;
   logic        memreq_rdy;
   logic [46:0] memresp_msg;
   logic        memresp_val;
   logic        memresp_rdy;

   int checks   = 0;
   int failures = 0;

   cache_mem_responder #(.p_num_words(256), .p_latency(LAT)) dut (
      .clk         (clk),
      .reset       (reset),
      .memreq_msg  (memreq_msg),
      .memreq_val  (memreq_val),
      .memreq_rdy  (memreq_rdy),
      .memresp_msg (memresp_msg),
      .memresp_val (memresp_val),
      .memresp_rdy (memresp_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] len);
      int n;
      n = 0;
      @(negedge clk);
      while (!memreq_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("req_rdy_wait", memreq_rdy, 1);
      memreq_msg = {t, op, addr, len, data};
      memreq_val = 1'b1;
      @(posedge clk);
      #1;
      memreq_val = 1'b0;
   endtask

   task automatic xact(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] len,
                       input logic [31:0] exp_data, input int hold);
      int          lat;
      logic        rdy_low;
      logic [46:0] m;
      memresp_rdy = (hold == 0);
      send(t, op, addr, data, len);
      lat     = 0;
      rdy_low = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         if (memreq_rdy) rdy_low = 1'b0;
      end while (!memresp_val && lat < 100);
      check("resp_latency", lat, LAT + 1);
      check("req_rdy_pending", rdy_low, 1);
      m = memresp_msg;
      check("resp_type", m[46:44], t);
      check("resp_opaque", m[43:36], op);
      check("resp_test", m[35:34], 0);
      check("resp_len", m[33:32], len);
      check("resp_data", m[31:0], exp_data);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_val", memresp_val, 1);
         check("hold_msg", memresp_msg, m);
         check("hold_req_rdy", memreq_rdy, 0);
      end
      memresp_rdy = 1'b1;
      @(negedge clk);
      check("done_val", memresp_val, 0);
      check("done_req_rdy", memreq_rdy, 1);
      $display("xact type=%0d opaque=%02h addr=%08h data=%08h resp_data=%08h lat=%0d hold=%0d",
               t, op, addr, data, m[31:0], lat, hold);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset       = 1'b1;
      memreq_val  = 1'b0;
      memreq_msg  = '0;
      memresp_rdy = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req_rdy", memreq_rdy, 1);
      check("rst_resp_val", memresp_val, 0);
      check("rst_resp_msg", memresp_msg, 0);
      reset = 1'b0;

      // INIT then READ of the same word
      xact(3'd2, 8'h11, 32'h0000_1000, 32'hDEAD_BEEF, 2'd0, 32'h0, 0);
      xact(3'd0, 8'h5A, 32'h0000_1000, 32'h0, 2'd0, 32'hDEAD_BEEF, 0);
      xact(3'd0, 8'h3C, 32'h0000_1000, 32'h0, 2'd2, 32'hDEAD_BEEF, 0);

      // 16-word line written, then read back in order
      for (int i = 0; i < 16; i++)
         xact(3'd1, 8'(i), 32'h0000_2000 + 32'(i * 4), 32'h100 + 32'(i), 2'd0, 32'h0, 0);
      for (int i = 0; i < 16; i++)
         xact(3'd0, 8'(8'h40 + i), 32'h0000_2000 + 32'(i * 4), 32'h0, 2'd0, 32'h100 + 32'(i), 0);

      // Response held for 5 cycles with memresp_rdy low
      xact(3'd0, 8'hC3, 32'h0000_2004, 32'h0, 2'd1, 32'h101, 5);

      // Unknown type: no write, zero data, type echoed
      xact(3'd5, 8'h77, 32'h0000_2008, 32'hFFFF_FFFF, 2'd3, 32'h0, 0);
      xact(3'd0, 8'h78, 32'h0000_2008, 32'h0, 2'd0, 32'h102, 0);

      // Address wrap modulo store size
      xact(3'd2, 8'h01, 32'h0000_0000, 32'h77, 2'd0, 32'h0, 0);
      xact(3'd0, 8'h02, 32'h0000_0400, 32'h0, 2'd0, 32'h77, 0);

      // Reset while the WRITE response is in WAIT
      memresp_rdy = 1'b1;
      send(3'd1, 8'h99, 32'h0000_3004, 32'h1234_5678, 2'd0);
      @(negedge clk);
      check("wait_req_rdy", memreq_rdy, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_resp_val", memresp_val, 0);
      check("midrst_req_rdy", memreq_rdy, 1);
      @(negedge clk);
      check("postrst_resp_val", memresp_val, 0);
      check("postrst_req_rdy", memreq_rdy, 1);
      xact(3'd0, 8'hAB, 32'h0000_3004, 32'h0, 2'd0, 32'h1234_5678, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Memory-side responder for the cache's refill/writeback port.
- Accepts mem_req_4B_t word requests, such as the 16-request line bursts the cache sends on refill and writeback, and executes each against a word-addressed backing store.
- Returns one mem_resp_4B_t per request, in order, after a fixed configurable latency.
- Used as the test memory behind the cache in unit and integration benches.

Parameters:
- p_num_words, 256: backing store depth in 32-bit words; must be a power of 2 and at least 16.
- p_latency, 2: extra cycles between request accept and response valid; range 0..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- memreq_msg  in  77  mem_req_4B_t {type_[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}
- memreq_val  in  1  request valid
- memreq_rdy  out  1  request ready
- memresp_msg  out  47  mem_resp_4B_t {type_[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0]}
- memresp_val  out  1  response valid
- memresp_rdy  in  1  response ready

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, memreq_rdy=1, memresp_val=0, memresp_msg=0, latency counter=0.
  - Backing store is NOT cleared by reset; contents are loaded via INIT/WRITE messages.
- Word index: addr[log2(p_num_words)+1:2]. addr[1:0] and upper bits are ignored, so out-of-range addresses wrap modulo the store size.
- Handshake: a transfer occurs on val&rdy at a rising edge. One request is outstanding at a time, and memreq_rdy is high only in IDLE.
- FSM states:
  - IDLE:
    - memreq_rdy=1.
    - On accept, latch type_, opaque, len and the read word store[idx].
    - If type_ is WRITE(1) or INIT(2), write data to store[idx] at the same edge; the latched read word is the pre-write value and is unused.
    - Load counter with p_latency.
    - Next state is WAIT if p_latency>0, else RESP.
  - WAIT:
    - Counter decrements each cycle.
    - When the counter is 1, go to RESP.
    - Both valids are low.
  - RESP:
    - memresp_val=1.
    - memresp_msg = {type_ echoed, opaque echoed, test=2'b0, len echoed, data}.
    - data is the latched word for READ(0) and 0 for every other type.
    - On memresp_rdy, go to IDLE.
    - Once asserted, memresp_val and memresp_msg hold stable until accepted.
- Latency: request accepted at edge T gives memresp_val high from cycle T+1+p_latency. Back-to-back throughput is 1 request per (p_latency+2) cycles with memresp_rdy held high.
- Unknown type_ values (3..7): no store write, data=0, type_ echoed.
- memresp_rdy held low: remain in RESP indefinitely; memreq_rdy stays 0.
- Write then read to the same address: the read returns the new data, because requests are serialised.
- len: echoed only. All writes are full 32-bit words regardless of len.
- Reset asserted mid-transaction: the in-flight response is discarded and the FSM returns to IDLE the next cycle. A write already accepted before reset remains in the store.

Optional Feature:
- Macro name: CACHE_MEM_RESP_STALL_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every cycle.
  - On entering RESP, and while memresp_val has not yet been asserted for the current response, any cycle with lfsr[0]=1 keeps memresp_val low.
  - After the first assertion, memresp_val holds until accepted.
  - Response order and contents are unchanged.
- When undefined: the LFSR is absent and RESP asserts memresp_val immediately.

Test Plan:
1. Reset, then INIT addr 0x1000 data 0xDEADBEEF, then READ addr 0x1000 opaque 0x5A -> READ response: type 0, opaque 0x5A, data 0xDEADBEEF. The INIT response has type 2 and data 0.
2. With p_latency=2, accept a READ at cycle 10 -> memresp_val rises in cycle 13; memreq_rdy=0 in cycles 11-13.
3. WRITE 16 words 0x2000..0x203C with data i+0x100, then READ all 16 with memresp_rdy=1 -> 16 responses in order, data 0x100..0x10F. No request is accepted while a response is pending.
4. Hold memresp_rdy=0 for 5 cycles during RESP -> memresp_val and memresp_msg stay stable; the single accept occurs on the first rdy cycle.
5. With p_num_words=256, READ addr 0x400 after INIT addr 0x0 data 0x77 -> data 0x77 (wrap-around).
6. Assert reset in WAIT -> memresp_val stays 0 and memreq_rdy=1 the cycle after reset; a following READ returns the data written before reset.
